// File: rtl/eth_tx_arbiter.sv
// Two-source transmit arbiter in front of the Ethernet frame builder.
// Grants one AXI-stream payload source at a time (round-robin on ties),
// latches that source's destination MAC and EtherType for the framer,
// marks the first byte with tuser, caps the frame length and inserts a
// fixed inter-frame gap before the next grant.
module eth_tx_arbiter #(
    parameter int IFG_CYCLES = 12,   // idle cycles after each frame, 1..255
    parameter int MAX_LEN    = 1500  // max payload bytes per frame, 2..2047
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,

    input  logic [47:0] s0_dst_mac,
    input  logic [15:0] s0_eth_type,
    input  logic [7:0]  s0_axis_tdata,
    input  logic        s0_axis_tvalid,
    input  logic        s0_axis_tlast,
    output logic        s0_axis_tready,

    input  logic [47:0] s1_dst_mac,
    input  logic [15:0] s1_eth_type,
    input  logic [7:0]  s1_axis_tdata,
    input  logic        s1_axis_tvalid,
    input  logic        s1_axis_tlast,
    output logic        s1_axis_tready,

    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,

    output logic [47:0] dst_mac,
    output logic [15:0] eth_type,
    output logic [1:0]  grant,
    output logic        trunc_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DROP,
        ST_GAP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  grant_q;     // owner of the current frame, kept through DROP
    logic        rr_q;        // source granted last: 0 = s0, 1 = s1
    logic [10:0] byte_cnt;
    logic        first_beat;
    logic [7:0]  gap_cnt;
    logic        trunc_q;
    logic [47:0] dst_mac_q;
    logic [15:0] eth_type_q;

    logic        src_tvalid;
    logic        src_tlast;
    logic [7:0]  src_tdata;
    logic        req_any;
    logic        win;         // 0 = s0 wins, 1 = s1 wins
    logic        at_max;
    logic        gap_done;
    logic        hs;
    logic        trunc_now;

    assign req_any   = s0_axis_tvalid | s1_axis_tvalid;
    // A lone requester wins; on a tie the source that was not granted last wins.
    assign win       = (s0_axis_tvalid & s1_axis_tvalid) ? ~rr_q : s1_axis_tvalid;
    assign at_max    = (byte_cnt == 11'(MAX_LEN - 1));
    assign gap_done  = (gap_cnt == 8'(IFG_CYCLES - 1));
    assign hs        = (state == ST_XFER) & src_tvalid & m_axis_tready;
    assign trunc_now = hs & ~src_tlast & at_max;

    assign dst_mac   = dst_mac_q;
    assign eth_type  = eth_type_q;
    assign trunc_err = trunc_q;

    // Select the granted source's stream signals.
    always_comb begin
        src_tvalid = grant_q[1] ? s1_axis_tvalid : s0_axis_tvalid;
        src_tlast  = grant_q[1] ? s1_axis_tlast  : s0_axis_tlast;
        src_tdata  = grant_q[1] ? s1_axis_tdata  : s0_axis_tdata;
    end

    // State register.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    // Next-state decode and the combinational stream/handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt      = state;
        grant          = 2'b00;
        m_axis_tdata   = 8'h00;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                grant          = grant_q;
                m_axis_tdata   = src_tdata;
                m_axis_tvalid  = src_tvalid;
                m_axis_tlast   = src_tvalid & (src_tlast | at_max);
                m_axis_tuser   = src_tvalid & first_beat;
                s0_axis_tready = grant_q[0] & m_axis_tready;
                s1_axis_tready = grant_q[1] & m_axis_tready;
                if (hs) begin
                    if (src_tlast)   state_nxt = ST_GAP;
                    else if (at_max) state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                // Swallow the rest of an over-length frame from its owner.
                s0_axis_tready = grant_q[0];
                s1_axis_tready = grant_q[1];
                if (src_tvalid & src_tlast) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant, frame header latches, byte/gap counters and truncation pulse.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            grant_q    <= 2'b00;
            rr_q       <= 1'b1;
            byte_cnt   <= '0;
            first_beat <= 1'b0;
            gap_cnt    <= '0;
            trunc_q    <= 1'b0;
            dst_mac_q  <= '0;
            eth_type_q <= '0;
        end else begin
            trunc_q <= trunc_now;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;
            if (state == ST_IDLE && req_any) begin
                grant_q    <= win ? 2'b10 : 2'b01;
                rr_q       <= win;
                dst_mac_q  <= win ? s1_dst_mac  : s0_dst_mac;
                eth_type_q <= win ? s1_eth_type : s0_eth_type;
                byte_cnt   <= '0;
                first_beat <= 1'b1;
            end else if (hs) begin
                byte_cnt   <= byte_cnt + 11'd1;
                first_beat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter (IFG 12, MAX_LEN 64).
module tb_eth_tx_arbiter;

    localparam int IFG  = 12;
    localparam int MAXL = 64;

    logic        s_axis_aclk = 1'b0;
    logic        s_axis_aresetn;
    logic [47:0] s0_dst_mac, s1_dst_mac;
    logic [15:0] s0_eth_type, s1_eth_type;
    logic [7:0]  s0_axis_tdata, s1_axis_tdata;
    logic        s0_axis_tvalid, s1_axis_tvalid;
    logic        s0_axis_tlast, s1_axis_tlast;
    logic        s0_axis_tready, s1_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [47:0] dst_mac;
    logic [15:0] eth_type;
    logic [1:0]  grant;
    logic        trunc_err;

    eth_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL)) dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_aresetn(s_axis_aresetn),
        .s0_dst_mac    (s0_dst_mac),
        .s0_eth_type   (s0_eth_type),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast (s0_axis_tlast),
        .s0_axis_tready(s0_axis_tready),
        .s1_dst_mac    (s1_dst_mac),
        .s1_eth_type   (s1_eth_type),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast (s1_axis_tlast),
        .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .dst_mac       (dst_mac),
        .eth_type      (eth_type),
        .grant         (grant),
        .trunc_err     (trunc_err)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge s_axis_aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output log, filled at the falling edge ahead of each handshake edge.
    logic [7:0]  out_data[$];
    logic        out_user[$];
    logic        out_last[$];
    logic [47:0] out_mac[$];
    logic [15:0] out_type[$];
    logic [1:0]  frame_grant[$];
    int          frame_start[$];
    int          gaps[$];
    int          tlast_edges[$];
    int          trunc_cycs[$];
    int          last_tlast_edge = -1;
    int          first_s0_rdy = -1;
    logic        prev_tuser = 1'b0;
    logic [7:0]  exp_data[$];

    always @(negedge s_axis_aclk) begin
        if (s_axis_aresetn) begin
            if (m_axis_tuser && !prev_tuser) begin
                frame_grant.push_back(grant);
                frame_start.push_back(cyc);
                if (last_tlast_edge >= 0) gaps.push_back(cyc - last_tlast_edge);
            end
            prev_tuser = m_axis_tuser;
            if (m_axis_tvalid && m_axis_tready) begin
                out_data.push_back(m_axis_tdata);
                out_user.push_back(m_axis_tuser);
                out_last.push_back(m_axis_tlast);
                out_mac.push_back(dst_mac);
                out_type.push_back(eth_type);
                if (m_axis_tlast) begin
                    last_tlast_edge = cyc + 1;
                    tlast_edges.push_back(cyc + 1);
                end
            end
            if (trunc_err) trunc_cycs.push_back(cyc);
            if (s0_axis_tready && first_s0_rdy < 0) first_s0_rdy = cyc;
        end
    end

    task automatic clear_log();
        out_data.delete(); out_user.delete(); out_last.delete();
        out_mac.delete(); out_type.delete(); frame_grant.delete();
        frame_start.delete(); gaps.delete(); tlast_edges.delete();
        trunc_cycs.delete(); exp_data.delete();
        last_tlast_edge = -1;
        first_s0_rdy    = -1;
    endtask

    function automatic int stream_errors();
        int e = 0;
        if (out_data.size() != exp_data.size()) e++;
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++)
            if (out_data[i] !== exp_data[i]) e++;
        return e;
    endfunction

    function automatic int count_user();
        int n = 0;
        foreach (out_user[i]) if (out_user[i]) n++;
        return n;
    endfunction

    function automatic int count_last();
        int n = 0;
        foreach (out_last[i]) if (out_last[i]) n++;
        return n;
    endfunction

    function automatic logic [1:0] fg(input int i);
        if (i < frame_grant.size()) return frame_grant[i];
        return 2'bxx;
    endfunction

    function automatic int qi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -99;
    endfunction

    function automatic logic ol(input int i);
        if (i < out_last.size()) return out_last[i];
        return 1'bx;
    endfunction

    function automatic logic [47:0] om(input int i);
        if (i < out_mac.size()) return out_mac[i];
        return 'x;
    endfunction

    task automatic push_exp(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) exp_data.push_back(base + 8'(i));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge s_axis_aclk);
            #1;
        end
    endtask

    task automatic drive_src(input int s, input logic v, input logic [7:0] d, input logic l);
        if (s == 0) begin
            s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l;
        end else begin
            s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l;
        end
    endtask

    task automatic set_cfg(input int s, input logic [47:0] mac, input logic [15:0] et);
        if (s == 0) begin
            s0_dst_mac = mac; s0_eth_type = et;
        end else begin
            s1_dst_mac = mac; s1_eth_type = et;
        end
    endtask

    // Send one frame of bytes base, base+1, ...; returns just after the
    // edge on which the last byte is accepted.
    task automatic send_frame(input int s, input int len, input logic [7:0] base);
        logic rdy;
        int   waited;
        for (int i = 0; i < len; i++) begin
            drive_src(s, 1'b1, base + 8'(i), i == len - 1);
            waited = 0;
            rdy    = 1'b0;
            while (!rdy && waited < 500) begin
                @(negedge s_axis_aclk);
                rdy = (s == 0) ? s0_axis_tready : s1_axis_tready;
                @(posedge s_axis_aclk);
                #1;
                waited++;
            end
            if (!rdy) begin
                check($sformatf("src%0d_accept_timeout", s), 64'(rdy), 64'd1);
                drive_src(s, 1'b0, 8'h00, 1'b0);
                return;
            end
        end
        drive_src(s, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic apply_reset();
        s_axis_aresetn = 1'b0;
        tick(3);
        s_axis_aresetn = 1'b1;
    endtask

    // Framer ready: constant high, or the repeating 1,0,0,1 pattern.
    logic       bp_mode = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;
    int         bp_idx  = 0;

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge s_axis_aclk);
            #1;
            if (bp_mode) begin
                m_axis_tready = bp_pat[bp_idx];
                bp_idx = (bp_idx + 1) % 4;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_req;
        int nz;
        int bad;
        int w;

        s_axis_aresetn = 1'b0;
        drive_src(0, 1'b0, 8'h00, 1'b0);
        drive_src(1, 1'b0, 8'h00, 1'b0);
        set_cfg(0, 48'h0, 16'h0);
        set_cfg(1, 48'h0, 16'h0);
        apply_reset();

        // Reset state.
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_treadys", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
        check("rst_m_axis", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 64'd0);
        check("rst_dst_mac", 64'(dst_mac), 64'd0);
        check("rst_eth_type", 64'(eth_type), 64'd0);
        check("rst_trunc_err", 64'(trunc_err), 64'd0);

        // Single source, 46 bytes; source config changes mid-frame.
        clear_log();
        set_cfg(0, 48'h0A0B0C0D0E0F, 16'h0800);
        t_req = cyc;
        fork
            send_frame(0, 46, 8'h00);
            begin
                tick(10);
                set_cfg(0, 48'hFFEEDDCCBBAA, 16'h86DD);
            end
        join
        nz = 0;
        repeat (IFG) begin
            @(negedge s_axis_aclk);
            if (grant !== 2'b00) nz++;
        end
        check("t1_gap_grant_nonzero", 64'(nz), 64'd0);
        push_exp(46, 8'h00);
        check("t1_data_errors", 64'(stream_errors()), 64'd0);
        check("t1_grant", 64'(fg(0)), 64'd1);
        check("t1_grant_latency", 64'(qi(frame_start, 0)), 64'(t_req + 1));
        check("t1_tuser_count", 64'(count_user()), 64'd1);
        check("t1_tuser_first", 64'(out_user.size() > 0 && out_user[0]), 64'd1);
        check("t1_tlast_count", 64'(count_last()), 64'd1);
        check("t1_tlast_on_2d", 64'(ol(45)), 64'd1);
        bad = 0;
        foreach (out_mac[i]) if (out_mac[i] !== 48'h0A0B0C0D0E0F || out_type[i] !== 16'h0800) bad++;
        check("t1_hdr_unstable", 64'(bad), 64'd0);
        check("t1_trunc_pulses", 64'(trunc_cycs.size()), 64'd0);
        tick(20);

        // Simultaneous requests from reset, 3 x 10-byte frames each.
        apply_reset();
        clear_log();
        set_cfg(0, 48'h00AA00AA00AA, 16'h0800);
        set_cfg(1, 48'h00BB00BB00BB, 16'h86DD);
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(0, 10, 8'(16 * f));
            end
            begin
                for (int f = 0; f < 3; f++) send_frame(1, 10, 8'(8'h80 + 16 * f));
            end
        join
        for (int f = 0; f < 3; f++) begin
            push_exp(10, 8'(16 * f));
            push_exp(10, 8'(8'h80 + 16 * f));
        end
        check("t2_data_errors", 64'(stream_errors()), 64'd0);
        check("t2_frame_count", 64'(frame_grant.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("t2_grant_%0d", k), 64'(fg(k)), (k % 2 == 0) ? 64'd1 : 64'd2);
        check("t2_gap_count", 64'(gaps.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            check($sformatf("t2_gap_%0d", k), 64'(qi(gaps, k)), 64'(IFG + 1));
        check("t2_mac_s0", 64'(om(0)), 64'h00AA00AA00AA);
        check("t2_mac_s1", 64'(om(10)), 64'h00BB00BB00BB);
        tick(20);

        // Backpressure 1,0,0,1 on s1's 20-byte frame while s0 waits.
        clear_log();
        set_cfg(1, 48'h00CC00CC00CC, 16'h0806);
        bp_idx  = 0;
        bp_mode = 1'b1;
        fork
            send_frame(1, 20, 8'h40);
            begin
                tick(2);
                send_frame(0, 4, 8'hA0);
            end
        join
        bp_mode = 1'b0;
        push_exp(20, 8'h40);
        push_exp(4, 8'hA0);
        check("t3_data_errors", 64'(stream_errors()), 64'd0);
        check("t3_grant_s1", 64'(fg(0)), 64'd2);
        check("t3_grant_s0", 64'(fg(1)), 64'd1);
        check("t3_gap", 64'(qi(gaps, 0)), 64'(IFG + 1));
        check("t3_s0_ready_after_gap",
              64'(first_s0_rdy >= qi(tlast_edges, 0) + IFG + 1), 64'd1);
        tick(20);

        // Truncation: s0 sends 100 bytes, s1 pending.
        clear_log();
        fork
            send_frame(0, 100, 8'h00);
            begin
                tick(3);
                send_frame(1, 5, 8'hC0);
            end
        join
        push_exp(MAXL, 8'h00);
        push_exp(5, 8'hC0);
        check("t4_data_errors", 64'(stream_errors()), 64'd0);
        check("t4_forced_tlast", 64'(ol(MAXL - 1)), 64'd1);
        check("t4_tlast_count", 64'(count_last()), 64'd2);
        check("t4_trunc_pulses", 64'(trunc_cycs.size()), 64'd1);
        check("t4_trunc_timing", 64'(qi(trunc_cycs, 0)), 64'(qi(tlast_edges, 0)));
        check("t4_next_grant_s1", 64'(fg(1)), 64'd2);
        tick(20);

        // Exactly MAX_LEN bytes with source tlast: no truncation, no DROP.
        clear_log();
        fork
            send_frame(0, MAXL, 8'h20);
            begin
                tick(3);
                send_frame(1, 3, 8'hD0);
            end
        join
        push_exp(MAXL, 8'h20);
        push_exp(3, 8'hD0);
        check("t5_data_errors", 64'(stream_errors()), 64'd0);
        check("t5_trunc_pulses", 64'(trunc_cycs.size()), 64'd0);
        check("t5_tlast_last", 64'(ol(MAXL - 1)), 64'd1);
        check("t5_gap", 64'(qi(gaps, 0)), 64'(IFG + 1));
        check("t5_next_grant_s1", 64'(fg(1)), 64'd2);
        tick(20);

        // Reset asserted at byte 5 of an s0 frame.
        clear_log();
        set_cfg(0, 48'h111111111111, 16'h1111);
        drive_src(0, 1'b1, 8'h55, 1'b0);
        w = 0;
        while (out_data.size() < 5 && w < 50) begin
            tick(1);
            w++;
        end
        check("t6_reached_byte5", 64'(out_data.size() >= 5), 64'd1);
        #2;
        s_axis_aresetn = 1'b0;
        #1;
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_m_axis", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 64'd0);
        check("t6_rst_treadys", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
        check("t6_rst_hdr", 64'({dst_mac != 48'h0, eth_type != 16'h0}), 64'd0);
        drive_src(0, 1'b0, 8'h00, 1'b0);
        tick(2);
        clear_log();
        s_axis_aresetn = 1'b1;
        fork
            send_frame(0, 3, 8'h60);
            send_frame(1, 3, 8'h70);
        join
        push_exp(3, 8'h60);
        push_exp(3, 8'h70);
        check("t6_data_errors", 64'(stream_errors()), 64'd0);
        check("t6_first_grant_s0", 64'(fg(0)), 64'd1);
        check("t6_second_grant_s1", 64'(fg(1)), 64'd2);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Two-source transmit arbiter that sequences and shares the Ethernet frame builder. It selects one of two 8-bit AXI-stream payload sources, latches that source's destination MAC and EtherType for the framer, and forwards the payload with a start-of-frame marker. It enforces frame length and inter-frame gap, and it sits directly upstream of the frame builder in the transmit path.

## Interface
- IFG_CYCLES, 12: idle cycles inserted after each frame before the next grant (range 1..255).
- MAX_LEN, 1500: maximum payload bytes per frame; longer frames are truncated (range 2..2047).
- s_axis_aclk  in  1  single clock, rising edge.
- s_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- s0_dst_mac / s1_dst_mac  in  48  per-source destination MAC.
- s0_eth_type / s1_eth_type  in  16  per-source EtherType.
- s0_axis_tdata / s1_axis_tdata  in  8  payload byte.
- s0_axis_tvalid / s1_axis_tvalid  in  1  byte valid; a tvalid outside a frame is a request.
- s0_axis_tlast / s1_axis_tlast  in  1  last payload byte.
- s0_axis_tready / s1_axis_tready  out  1  source ready.
- m_axis_tdata  out  8  payload to framer.
- m_axis_tvalid  out  1  payload valid.
- m_axis_tlast  out  1  last byte, including forced truncation.
- m_axis_tuser  out  1  high on the first byte of a frame only.
- m_axis_tready  in  1  framer ready.
- dst_mac  out  48  latched destination MAC for the current frame.
- eth_type  out  16  latched EtherType for the current frame.
- grant  out  2  one-hot owner (bit0 = s0); 00 when not in XFER.
- trunc_err  out  1  one-cycle pulse when a frame is truncated.

## Operation
- State machine: IDLE, XFER, DROP, GAP.
- IDLE transitions:
  - Requests are the s0/s1 tvalid signals.
  - With no request, stay in IDLE.
  - With a request, go to XFER and set the grant register.
  - Latch dst_mac and eth_type from the winner in the same clock edge.
  - Clear the byte counter and set first_beat.
- Arbitration is round-robin using the rr register, which names the source last granted.
  - On a simultaneous request, the source other than rr wins.
  - A single requester always wins.
  - rr updates at grant time.
- XFER datapath:
  - m_axis_tdata and m_axis_tvalid are a combinational mux of the granted source.
  - Granted source tready = m_axis_tready; the other source's tready = 0.
  - m_axis_tuser = first_beat & m_axis_tvalid. first_beat clears on the first handshake.
  - A handshake is m_axis_tvalid & m_axis_tready. Each handshake increments the 11-bit byte counter.
- XFER end of frame:
  - m_axis_tlast = source tlast OR (counter == MAX_LEN-1).
  - On a handshake with source tlast, go to GAP.
  - On a handshake at counter == MAX_LEN-1 with source tlast low: pulse trunc_err and go to DROP.
- DROP:
  - Granted source tready = 1 and m_axis_tvalid = 0; bytes are discarded.
  - On source tvalid & tlast, go to GAP.
- GAP:
  - grant = 00 and all source treadys = 0.
  - The gap counter counts IFG_CYCLES cycles, then the state returns to IDLE.
- dst_mac and eth_type hold their values until the next grant. Config changes mid-frame are ignored.
- A source dropping tvalid mid-frame stalls the output. There is no timeout.

## Timing
- Reset values:
  - State IDLE, grant 00, rr = s1 (so s0 wins the first tie).
  - trunc_err 0; all treadys 0; m_axis_tvalid, tlast, tuser 0.
  - dst_mac 0, eth_type 0, both counters 0.
- Reset asserted mid-frame:
  - All outputs reach their reset values immediately.
  - The partial frame is abandoned and there is no tlast.
- Grant latency: a request sampled in IDLE at edge N gives grant, m_axis_tvalid and tuser at cycle N+1. The first byte can transfer at edge N+1.
- Throughput: 1 byte/cycle while tvalid and tready are both high. There are no bubbles inside XFER.
- Frame spacing: with the last handshake at edge T, the state is GAP for IFG_CYCLES cycles, reaches IDLE at edge T+IFG_CYCLES, and the next grant appears at T+IFG_CYCLES+1.
- A single-byte frame (tvalid and tlast on the first byte) has tuser and tlast in the same cycle.
- Truncation boundary:
  - A frame of exactly MAX_LEN bytes with source tlast on byte MAX_LEN is not a truncation. There is no pulse and the state goes straight to GAP.
  - trunc_err is registered and fires the cycle after the forced-tlast handshake.

## Test plan
- Single source: s0 sends 46 bytes 0x00..0x2D with dst_mac 0x0A0B0C0D0E0F and eth_type 0x0800.
  - Expect grant=01 one cycle after tvalid, and tuser on byte 0x00 only.
  - Expect tlast on 0x2D, dst_mac and eth_type stable across the frame, and grant 00 for 12 cycles after.
- Simultaneous requests from reset, with s0 and s1 each sending 3 frames of 10 bytes:
  - Expect grant order s0,s1,s0,s1,s0,s1.
  - Expect exactly IFG_CYCLES+1 cycles between each tlast handshake and the next tuser.
- Backpressure: s1 sends 20 bytes while m_axis_tready toggles 1,0,0,1 and s0 continuously requests.
  - Expect the output byte sequence intact with no duplicates.
  - Expect s0_axis_tready to stay 0 until s1's frame is done and the gap has elapsed.
- Truncation with MAX_LEN=64: s0 sends 100 bytes.
  - Expect 64 output bytes with tlast on byte 64, and trunc_err pulsed once.
  - Expect the remaining 36 bytes accepted with no output, then GAP, IDLE, and a grant to s1 if it is pending.
- Exact MAX_LEN frame (64 bytes, tlast on byte 64) -> no trunc_err pulse and no DROP.
- Reset asserted at byte 5 of a frame:
  - Expect all outputs 0 immediately.
  - After release with both sources requesting, expect s0 to win.
